out_mapper: RTL and testbench
=============================

Name: out_mapper

Overview:
- Receive-side mapper: converts SpiNNaker packets arriving from the SpiNNaker link receiver into AER events for the output AER device.
- Checks parity, forwards only multicast keys, and buffers events in a small FIFO.
- Enters dump mode when the AER device stalls or when commanded, so the SpiNNaker link is never back-pressured indefinitely.
- Exposes saturating error and drop counters for the status register bank.

Parameters:
- AER_WIDTH, 32, width of the output AER event; the low AER_WIDTH bits of the routing key are forwarded (1..32).
- FIFO_DEPTH, 4, number of AER events buffered (≥2).
- TIMEOUT, 128, consecutive stalled cycles before timeout dump engages (≤255).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- opkt_data  in  72  SpiNNaker packet: [7:0] header, [39:8] key, [71:40] payload
- opkt_vld  in  1  packet valid
- opkt_rdy  out  1  packet accepted when opkt_vld & opkt_rdy
- oaer_data  out  AER_WIDTH  AER event = key[AER_WIDTH-1:0]
- oaer_vld  out  1  event valid
- oaer_rdy  in  1  AER device ready
- dump_on  in  1  one-cycle command: force dump
- dump_off  in  1  one-cycle command: release forced dump
- cnt_clear  in  1  one-cycle command: zero both counters
- dump_mode  out  1  1 = packets discarded
- parity_err_cnt  out  16  saturating count of parity-failed packets
- drop_cnt  out  16  saturating count of non-MC packets and packets discarded in dump

Behaviour:
- Reset (sync, rst=1 at edge):
  - FIFO empty; oaer_vld=0; oaer_data=0.
  - cmd_dump=1, so dump_mode=1 (block starts dumping until dump_off).
  - Timeout counter=TIMEOUT; timeout flag=0.
  - Both counters=0.
  - A reset mid-operation discards all buffered events with no partial output.
- Header decode:
  - bit0 = parity.
  - bit1 = payload present.
  - bits[7:6] = type (00 = multicast).
- Parity:
  - Packet length is 40 bits when bit1=0, 72 bits when bit1=1.
  - Valid iff the XOR of all bits of the packet length is 1 (odd parity).
- Acceptance:
  - opkt_rdy = ~fifo_full | dump_mode, combinational from registered state.
  - There is no pass-through when full: a simultaneous pop does not admit a write in the same cycle.
- Per accepted packet, first match applies:
  - dump_mode=1: discard; drop_cnt+1.
  - Parity bad: discard; parity_err_cnt+1.
  - Type≠00: discard; drop_cnt+1.
  - Otherwise: write key[AER_WIDTH-1:0] to the FIFO. Payload is ignored.
- Latency: packet accepted at edge N gives oaer_vld=1 in the cycle after edge N, if the FIFO was empty.
- FIFO:
  - In-order.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - Pop on oaer_vld & oaer_rdy.
  - oaer_vld = ~fifo_empty & ~dump_mode; oaer_data = head entry, 0 when empty.
- Dump drain: while dump_mode=1, the head is popped every cycle without output; drained entries are not counted.
- Timeout counter, per cycle:
  - If oaer_rdy=1 or the FIFO is empty: reload TIMEOUT; flag<=0.
  - Else if counter≠0: decrement; flag<=0.
  - Else: hold at 0; flag<=1.
- dump_mode is registered: dump_mode <= cmd_dump | flag.
  - Exit occurs 2 cycles after oaer_rdy returns high, provided cmd_dump=0.
- Commands:
  - dump_on sets cmd_dump; dump_off clears it.
  - If both are asserted in the same cycle, dump_on wins.
- Counters:
  - Saturate at 0xFFFF.
  - cnt_clear has priority over an increment in the same cycle.

Test Plan:
- Valid MC, AER_WIDTH=32:
  - Setup: rst, then dump_off. Send opkt_data={32'h0, 32'h12345678, 8'h00} with oaer_rdy=1.
  - Expected: oaer_data=32'h12345678 and oaer_vld=1 one cycle after acceptance; counters stay 0.
- Parity error: send {32'h0, 32'h12345678, 8'h01} → no oaer_vld; parity_err_cnt=1.
- Payload packet: send {32'hFFFFFFFF, 32'h12345678, 8'h03} → oaer_data=32'h12345678, payload dropped.
- Non-MC type: send {32'h0, 32'h12345678, 8'h41} → discarded; drop_cnt=1.
- Backpressure and timeout, oaer_rdy=0:
  - Send 4 packets with keys 0..3 → FIFO full; opkt_rdy=0.
  - After TIMEOUT+2 stalled cycles, dump_mode=1, opkt_rdy=1, FIFO drained.
  - A 5th packet gives drop_cnt=1.
  - Raise oaer_rdy → dump_mode=0 two cycles later.
- Reset/commands:
  - dump_on during traffic → packets discarded and drop_cnt counts them.
  - 65540 discarded packets → drop_cnt=0xFFFF.
  - cnt_clear concurrent with a drop → 0.
  - rst with FIFO holding 3 entries → oaer_vld=0 next cycle; dump_mode=1.

Source files
------------

// File: rtl/out_mapper.sv
// out_mapper: SpiNNaker receive-side packet to AER event mapper.
// Checks odd parity, forwards multicast keys through a small FIFO,
// and dumps traffic when the AER side stalls or when commanded.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opkt_data/vld/rdy   SpiNNaker packet in ([7:0] hdr, [39:8] key, [71:40] payload)
//   oaer_data/vld/rdy   AER event out (low AER_WIDTH key bits)
//   dump_on/dump_off    force / release dump mode (dump_on wins)
//   cnt_clear           zero both counters
//   dump_mode           1 while packets are discarded
//   parity_err_cnt      saturating count of parity failures
//   drop_cnt            saturating count of non-MC and dumped packets
module out_mapper #(
  parameter int AER_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [71:0]          opkt_data,
  input  logic                 opkt_vld,
  output logic                 opkt_rdy,
  output logic [AER_WIDTH-1:0] oaer_data,
  output logic                 oaer_vld,
  input  logic                 oaer_rdy,
  input  logic                 dump_on,
  input  logic                 dump_off,
  input  logic                 cnt_clear,
  output logic                 dump_mode,
  output logic [15:0]          parity_err_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [7:0]    TO_LOAD  = 8'(TIMEOUT);

  logic [AER_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 cmd_dump;
  logic [7:0]           to_cnt;
  logic                 to_flag;

  logic fifo_full;
  logic fifo_empty;
  logic accept;
  logic parity_ok;
  logic is_mc;
  logic push;
  logic pop;
  logic inc_perr;
  logic inc_drop;

  assign fifo_full  = (count == CNT_FULL);
  assign fifo_empty = (count == '0);

  assign opkt_rdy = ~fifo_full | dump_mode;
  assign accept   = opkt_vld & opkt_rdy;

  // Parity covers 40 bits, or all 72 when the payload flag is set.
  assign parity_ok = opkt_data[1] ? (^opkt_data) : (^opkt_data[39:0]);
  assign is_mc     = (opkt_data[7:6] == 2'b00);

  assign push     = accept & ~dump_mode & parity_ok & is_mc;
  assign inc_drop = accept & (dump_mode | (parity_ok & ~is_mc));
  assign inc_perr = accept & ~dump_mode & ~parity_ok;

  // In dump mode the head is drained every cycle with no output.
  assign pop = ~fifo_empty & (dump_mode | oaer_rdy);

  assign oaer_vld  = ~fifo_empty & ~dump_mode;
  assign oaer_data = fifo_empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= opkt_data[8 +: AER_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stall timer: flag raises once the counter has sat at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= TO_LOAD;
      to_flag <= 1'b0;
    end else if (oaer_rdy | fifo_empty) begin
      to_cnt  <= TO_LOAD;
      to_flag <= 1'b0;
    end else if (to_cnt != 8'd0) begin
      to_cnt  <= to_cnt - 8'd1;
      to_flag <= 1'b0;
    end else begin
      to_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_dump  <= 1'b1;
      dump_mode <= 1'b1;
    end else begin
      if (dump_on) begin
        cmd_dump <= 1'b1;
      end else if (dump_off) begin
        cmd_dump <= 1'b0;
      end
      dump_mode <= cmd_dump | to_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_cnt <= '0;
      drop_cnt       <= '0;
    end else if (cnt_clear) begin
      parity_err_cnt <= '0;
      drop_cnt       <= '0;
    end else begin
      if (inc_perr && parity_err_cnt != 16'hFFFF) begin
        parity_err_cnt <= parity_err_cnt + 16'd1;
      end
      if (inc_drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_out_mapper.sv
// tb_out_mapper: randomized and directed bench for out_mapper.
// Reference model plus scoreboard queue of expected AER events.
module tb_out_mapper;

  localparam int TO = 128;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [71:0] opkt_data = '0;
  logic        opkt_vld = 1'b0;
  logic        opkt_rdy;
  logic [31:0] oaer_data;
  logic        oaer_vld;
  logic        oaer_rdy = 1'b0;
  logic        dump_on = 1'b0;
  logic        dump_off = 1'b0;
  logic        cnt_clear = 1'b0;
  logic        dump_mode;
  logic [15:0] parity_err_cnt;
  logic [15:0] drop_cnt;

  out_mapper #(.AER_WIDTH(32), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(opkt_rdy),
    .oaer_data(oaer_data), .oaer_vld(oaer_vld), .oaer_rdy(oaer_rdy),
    .dump_on(dump_on), .dump_off(dump_off), .cnt_clear(cnt_clear),
    .dump_mode(dump_mode), .parity_err_cnt(parity_err_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] sb[$];
  bit m_cmd, m_flag, m_dm;
  int m_to, m_perr, m_drop;

  function automatic int sat(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  function automatic bit pkt_parity_ok(logic [71:0] d);
    int ones = 0;
    int len = d[1] ? 72 : 40;
    for (int i = 0; i < len; i++) ones += d[i];
    return (ones % 2) == 1;
  endfunction

  always @(negedge clk) begin : model
    bit full, empty, e_rdy, e_vld, acc, nflag;
    logic [31:0] e_data;
    if (started) begin
      full   = (m_q.size() == DEPTH);
      empty  = (m_q.size() == 0);
      e_rdy  = !full || m_dm;
      e_vld  = !empty && !m_dm;
      e_data = empty ? 32'h0 : m_q[0];
      chk("opkt_rdy", {31'h0, opkt_rdy}, {31'h0, e_rdy});
      chk("oaer_vld", {31'h0, oaer_vld}, {31'h0, e_vld});
      chk("oaer_data", oaer_data, e_data);
      chk("dump_mode", {31'h0, dump_mode}, {31'h0, m_dm});
      chk("parity_err_cnt", {16'h0, parity_err_cnt}, m_perr);
      chk("drop_cnt", {16'h0, drop_cnt}, m_drop);
      if (e_vld && oaer_rdy) sb.push_back(m_q[0]);
    end
    if (rst) begin
      started = 1;
      m_q.delete();
      m_cmd = 1; m_dm = 1; m_flag = 0;
      m_to = TO; m_perr = 0; m_drop = 0;
    end else if (started) begin
      acc = opkt_vld && e_rdy;
      if (!empty && (m_dm || oaer_rdy)) void'(m_q.pop_front());
      if (acc) begin
        if (m_dm) m_drop = sat(m_drop);
        else if (!pkt_parity_ok(opkt_data)) m_perr = sat(m_perr);
        else if (opkt_data[7:6] != 2'b00) m_drop = sat(m_drop);
        else m_q.push_back(opkt_data[39:8]);
      end
      if (cnt_clear) begin
        m_perr = 0; m_drop = 0;
      end
      if (oaer_rdy || empty) begin
        m_to = TO; nflag = 0;
      end else if (m_to != 0) begin
        m_to--; nflag = 0;
      end else begin
        nflag = 1;
      end
      m_dm = m_cmd || m_flag;
      m_flag = nflag;
      if (dump_on) m_cmd = 1;
      else if (dump_off) m_cmd = 0;
    end
  end

  // Monitor: pops an expected event whenever the DUT hands one over.
  always @(negedge clk) begin
    #1;
    if (started && !rst && oaer_vld && oaer_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", oaer_data, 32'hxxxxxxxx);
      end else begin
        chk("event_data", oaer_data, sb.pop_front());
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [71:0] mk_pkt(logic [31:0] key, logic [1:0] typ,
                                         bit pay, bit good, logic [31:0] pl);
    logic [71:0] p;
    p = {pay ? pl : 32'h0, key, typ, 4'h0, pay, 1'b0};
    if (pkt_parity_ok(p) != good) p[0] = 1'b1;
    return p;
  endfunction

  task automatic send(logic [71:0] d);
    opkt_data = d;
    opkt_vld = 1'b1;
    tick();
    opkt_vld = 1'b0;
  endtask

  initial begin
    int w;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_dump_mode", {31'h0, dump_mode}, 32'h1);
    chk("reset_oaer_vld", {31'h0, oaer_vld}, 32'h0);
    chk("reset_oaer_data", oaer_data, 32'h0);
    tick();
    dump_off = 1'b1;
    tick();
    dump_off = 1'b0;
    tick(2);

    oaer_rdy = 1'b1;
    send({32'h0, 32'h12345678, 8'h00});
    @(negedge clk);
    chk("mc_vld", {31'h0, oaer_vld}, 32'h1);
    chk("mc_data", oaer_data, 32'h12345678);
    tick(2);
    send({32'h0, 32'h12345678, 8'h01});
    tick(2);
    chk("perr_cnt", {16'h0, parity_err_cnt}, 32'h1);
    send({32'hFFFFFFFF, 32'h12345678, 8'h03});
    tick(2);
    send({32'h0, 32'h12345678, 8'h41});
    tick(2);
    chk("nonmc_drop", {16'h0, drop_cnt}, 32'h1);

    oaer_rdy = 1'b0;
    for (int k = 0; k < 4; k++) send(mk_pkt(k, 2'b00, 0, 1, 0));
    chk("full_rdy", {31'h0, opkt_rdy}, 32'h0);
    w = 0;
    while (!dump_mode && w < 400) begin
      tick();
      w++;
    end
    chk("timeout_engaged", {31'h0, dump_mode}, 32'h1);
    tick(2);
    send(mk_pkt(32'h5, 2'b00, 0, 1, 0));
    tick();
    oaer_rdy = 1'b1;
    tick(4);
    chk("timeout_exit", {31'h0, dump_mode}, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      opkt_vld  = ($urandom_range(0, 1) == 1);
      opkt_data = ($urandom_range(0, 1) == 1) ?
                  mk_pkt($urandom, 2'($urandom), 1'($urandom), 1'($urandom), $urandom) :
                  {$urandom, $urandom, 8'($urandom)};
      oaer_rdy  = ($urandom_range(0, 3) != 0);
      dump_on   = ($urandom_range(0, 199) == 0);
      dump_off  = ($urandom_range(0, 49) == 0);
      cnt_clear = ($urandom_range(0, 299) == 0);
      if ((c % 600) > 400) oaer_rdy = 1'b0;
      tick();
    end
    opkt_vld = 0; dump_on = 0; dump_off = 0; cnt_clear = 0;
    oaer_rdy = 1'b1;
    tick(4);

    dump_on = 1'b1;
    tick();
    dump_on = 1'b0;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    tick();
    opkt_vld = 1'b1;
    opkt_data = mk_pkt(32'hABCD, 2'b00, 0, 1, 0);
    tick(65540);
    opkt_vld = 1'b0;
    tick();
    chk("drop_saturate", {16'h0, drop_cnt}, 32'hFFFF);
    opkt_vld = 1'b1;
    cnt_clear = 1'b1;
    tick();
    opkt_vld = 1'b0;
    cnt_clear = 1'b0;
    chk("clear_priority", {16'h0, drop_cnt}, 32'h0);

    dump_off = 1'b1;
    tick();
    dump_off = 1'b0;
    tick(2);
    oaer_rdy = 1'b0;
    for (int k = 0; k < 3; k++) send(mk_pkt(32'h100 + k, 2'b00, 0, 1, 0));
    chk("pre_rst_vld", {31'h0, oaer_vld}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_vld", {31'h0, oaer_vld}, 32'h0);
    chk("rst_dump", {31'h0, dump_mode}, 32'h1);
    tick(3);
    chk("sb_empty", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
